mem_access_unit: RTL and testbench

Load/store bus master between the core datapath and the data bus. It takes single load/store requests and drives a Wishbone-style classic bus cycle with byte selects and lane-replicated write data. Load data is returned aligned and sign/zero-extended. Misaligned accesses, illegal sizes and bus timeouts are reported to the control unit as one-cycle flags.

---
 rtl/mem_access_pkg.sv | 27 ++
 rtl/mem_access_unit_load_extender.sv | 36 +++
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store bus master: FSM state
// encoding, access-size codes and the per-size byte-lane mask.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  // funct3[1:0] access size codes
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Byte-lane mask for an access of the given size, before shifting by offset.
  function automatic logic [7:0] mask_by_size(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Load data alignment: moves the addressed bytes down to bit 0, keeps only
// the access width and fills the upper bits with the sign or with zeros.
module load_extender
  import mem_access_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic [DATA_SIZE-1:0]             data,
  input  logic [$clog2(DATA_SIZE/8)-1:0]   off,
  input  logic [1:0]                       size,
  input  logic                             unsigned_ld,
  output logic [DATA_SIZE-1:0]             result
);

  logic [DATA_SIZE-1:0] shifted;
  logic                 sign_bit;
  int                   nbits;

  // Shift by the byte offset, then extend above the access width.
  always_comb begin
    shifted = data >> {off, 3'b000};
    case (size)
      SZ_B:    nbits = 8;
      SZ_H:    nbits = 16;
      SZ_W:    nbits = 32;
      default: nbits = DATA_SIZE;
    endcase
    // A full-width load has no bits to fill, so unsigned_ld has no effect on it.
    sign_bit = unsigned_ld ? 1'b0 : shifted[nbits-1];
    result   = '0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      result[i] = (i < nbits) ? shifted[i] : sign_bit;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus master. Accepts one load or store at a time from the core,
// runs a classic Wishbone-style cycle with byte selects and lane-replicated
// store data, and returns aligned, extended load data. Misaligned/illegal
// accesses and ack timeouts finish with a one-cycle flag alongside done.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_rd,
  input  logic                   req_wr,
  input  logic [DATA_SIZE-1:0]   addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  logic [1:0]             size,
  input  logic                   unsigned_ld,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   misaligned,
  output logic                   bus_error,
  output logic                   bus_cyc,
  output logic                   bus_stb,
  output logic                   bus_we,
  output logic [DATA_SIZE-1:0]   bus_addr,
  output logic [DATA_SIZE/8-1:0] bus_sel,
  output logic [DATA_SIZE-1:0]   bus_dat_o,
  input  logic [DATA_SIZE-1:0]   bus_dat_i,
  input  logic                   bus_ack
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Store data replicated across every lane of the access width, so the
  // slave finds it on whichever lanes bus_sel enables.
  function automatic logic [DATA_SIZE-1:0] replicate_store(input logic [DATA_SIZE-1:0] d,
                                                           input logic [1:0]           sz);
    logic [DATA_SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_SIZE; i++) begin
      case (sz)
        SZ_B:    r[i] = d[i % 8];
        SZ_H:    r[i] = d[i % 16];
        SZ_W:    r[i] = d[i % 32];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Natural-alignment check; a double on a 32-bit datapath is always rejected.
  function automatic logic check_misaligned(input logic [1:0] sz, input logic [2:0] off3);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off3[0];
      SZ_W:    return |off3[1:0];
      default: return (DATA_SIZE == 32) || (|off3);
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [DATA_SIZE-1:0] addr_q, addr_d;
  logic [BYTES-1:0]     sel_q, sel_d;
  logic [DATA_SIZE-1:0] dat_q, dat_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [OFF_W-1:0]     off_q, off_d;
  logic [DATA_SIZE-1:0] rd_q, rd_d;
  logic                 done_q, done_d;
  logic                 mis_q, mis_d;
  logic                 err_q, err_d;

  logic [BYTES-1:0]     sel_calc;
  logic [DATA_SIZE-1:0] ld_result;

  assign sel_calc = BYTES'(mask_by_size(size)) << addr[OFF_W-1:0];

  load_extender #(
    .DATA_SIZE (DATA_SIZE)
  ) u_load_extender (
    .data        (bus_dat_i),
    .off         (off_q),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .result      (ld_result)
  );

  // Next-state and registered-output logic for the IDLE/BUS/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_wr || req_rd) begin
          if (check_misaligned(size, addr[2:0])) begin
            // Rejected: straight to DONE without touching the bus.
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = BUS;
            cnt_d   = '0;
            cyc_d   = 1'b1;
            we_d    = req_wr;
            addr_d  = {addr[DATA_SIZE-1:OFF_W], {OFF_W{1'b0}}};
            sel_d   = sel_calc;
            dat_d   = replicate_store(wr_data, size);
            size_d  = size;
            uns_d   = unsigned_ld;
            off_d   = addr[OFF_W-1:0];
          end
        end
      end
      BUS: begin
        if (bus_ack) begin
          // Ack takes priority over a timeout expiring in the same cycle.
          state_d = DONE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            rd_d = ld_result;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any cycle in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      off_q   <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign rd_data    = rd_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign misaligned = mis_q;
  assign bus_error  = err_q;
  assign bus_cyc    = cyc_q;
  assign bus_stb    = cyc_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_sel    = sel_q;
  assign bus_dat_o  = dat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit instance with a short timeout carries
// the directed table, reset and random traffic; a 64-bit instance covers
// the doubleword lanes and 32-bit loads from the upper half.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clock, reset;
  logic        req_rd, req_wr, unsigned_ld, bus_ack;
  logic [1:0]  size;
  logic [31:0] addr, wr_data, bus_dat_i, rd_data, bus_addr, bus_dat_o;
  logic        busy, done, misaligned, bus_error, bus_cyc, bus_stb, bus_we;
  logic [3:0]  bus_sel;

  logic        r_req_rd, r_req_wr, r_uns, r_ack;
  logic [1:0]  r_size;
  logic [63:0] r_addr, r_wd, r_dat_i, r_rd, r_baddr, r_dat_o;
  logic        r_busy, r_done, r_mis, r_err, r_cyc, r_stb, r_we;
  logic [7:0]  r_sel;

  int          n_cmp, n_err;
  logic [31:0] exp_rd;

  mem_access_unit #(.DATA_SIZE(32), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
    .wr_data(wr_data), .size(size), .unsigned_ld(unsigned_ld), .rd_data(rd_data),
    .busy(busy), .done(done), .misaligned(misaligned), .bus_error(bus_error),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
  );

  mem_access_unit #(.DATA_SIZE(64), .TIMEOUT(TO)) dut64 (
    .clock(clock), .reset(reset), .req_rd(r_req_rd), .req_wr(r_req_wr), .addr(r_addr),
    .wr_data(r_wd), .size(r_size), .unsigned_ld(r_uns), .rd_data(r_rd),
    .busy(r_busy), .done(r_done), .misaligned(r_mis), .bus_error(r_err),
    .bus_cyc(r_cyc), .bus_stb(r_stb), .bus_we(r_we), .bus_addr(r_baddr),
    .bus_sel(r_sel), .bus_dat_o(r_dat_o), .bus_dat_i(r_dat_i), .bus_ack(r_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, got no end, required $finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    int          e_cyc;
    logic        e_mis;
    logic        e_err;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_dat;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: aligned, truncated, extended load value from the raw bus word.
  function automatic logic [63:0] ref_load(input logic [63:0] d, input int off, input int sz,
                                           input logic uns, input int dw);
    logic [63:0] v, m;
    int nb;
    nb = 8 << sz;
    if (nb > dw) nb = dw;
    v = d >> (8 * off);
    if (nb < 64) begin
      m = (64'd1 << nb) - 64'd1;
      v = v & m;
      if (!uns && v[nb-1]) v = v | ~m;
    end
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic ref_mis(input int sz, input logic [2:0] a, input int dw);
    case (sz)
      1:       return a[0];
      2:       return a[1:0] != 2'b00;
      3:       return (dw == 32) || (a != 3'b000);
      default: return 1'b0;
    endcase
  endfunction

  // One request on the 32-bit unit; ack_at = BUS cycle number that acks (0 = never).
  task automatic txn(input string nm, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                     input int ack_at, input int e_cyc, input logic e_mis, input logic e_err,
                     input logic [3:0] e_sel, input logic [31:0] e_addr,
                     input logic [31:0] e_dat, input logic [31:0] e_rd);
    int cyc_n, stb_n, busy_n, done_c, c;
    logic mis_s, err_s, we_s, done_x;
    logic [3:0] sel_s;
    logic [31:0] addr_s, dat_s, rd_s;
    cyc_n = 0; stb_n = 0; busy_n = 0; done_c = -1; c = 0;
    mis_s = 0; err_s = 0; we_s = 0; sel_s = 0; addr_s = 0; dat_s = 0; rd_s = 0;
    req_wr = wr; req_rd = !wr; size = sz; unsigned_ld = uns; addr = a; wr_data = wd;
    while (done_c < 0 && c < 20) begin
      @(posedge clock); @(negedge clock); c++;
      if (c == 1) begin
        req_wr = 0; req_rd = 0;
        addr = $urandom; wr_data = $urandom; size = 2'($urandom); unsigned_ld = 1'($urandom);
      end
      bus_ack = 0; bus_dat_i = $urandom;
      if (busy) busy_n++;
      if (bus_stb) stb_n++;
      if (bus_cyc) begin
        cyc_n++;
        sel_s = bus_sel; addr_s = bus_addr; dat_s = bus_dat_o; we_s = bus_we;
        if (cyc_n == ack_at) begin bus_ack = 1; bus_dat_i = rdat; end
      end
      if (done) begin
        done_c = c; mis_s = misaligned; err_s = bus_error; rd_s = rd_data;
      end
    end
    bus_ack = 0;
    @(posedge clock); @(negedge clock);
    done_x = done;
    if (busy) busy_n++;
    check($sformatf("%s cyc_cycles", nm), 64'(cyc_n), 64'(e_cyc));
    check($sformatf("%s stb_cycles", nm), 64'(stb_n), 64'(e_cyc));
    check($sformatf("%s busy_cycles", nm), 64'(busy_n), 64'(e_cyc + 1));
    check($sformatf("%s done_cycle", nm), 64'(done_c), 64'(e_cyc + 1));
    check($sformatf("%s misaligned", nm), 64'(mis_s), 64'(e_mis));
    check($sformatf("%s bus_error", nm), 64'(err_s), 64'(e_err));
    check($sformatf("%s rd_data", nm), 64'(rd_s), 64'(e_rd));
    check($sformatf("%s done_pulse_end", nm), 64'(done_x), 64'd0);
    if (e_cyc > 0) begin
      check($sformatf("%s bus_sel", nm), 64'(sel_s), 64'(e_sel));
      check($sformatf("%s bus_addr", nm), 64'(addr_s), 64'(e_addr));
      check($sformatf("%s bus_dat_o", nm), 64'(dat_s), 64'(e_dat));
      check($sformatf("%s bus_we", nm), 64'(we_s), 64'(wr));
    end
  endtask

  // One load on the 64-bit unit with a zero-wait slave.
  task automatic txn64(input string nm, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] rdat,
                       input logic [7:0] e_sel, input logic [63:0] e_addr, input logic [63:0] e_rd);
    int dc, c;
    logic [7:0] sel_s;
    logic [63:0] ad_s, rd_s;
    dc = -1; c = 0; sel_s = 0; ad_s = 0; rd_s = 0;
    r_req_rd = 1; r_req_wr = 0; r_size = sz; r_uns = uns; r_addr = a;
    while (dc < 0 && c < 20) begin
      @(posedge clock); @(negedge clock); c++;
      r_req_rd = 0; r_ack = 0; r_dat_i = {$urandom, $urandom};
      if (r_cyc) begin sel_s = r_sel; ad_s = r_baddr; r_ack = 1; r_dat_i = rdat; end
      if (r_done) begin dc = c; rd_s = r_rd; end
    end
    r_ack = 0;
    @(posedge clock); @(negedge clock);
    check($sformatf("%s done_cycle", nm), 64'(dc), 64'd2);
    check($sformatf("%s bus_sel", nm), 64'(sel_s), 64'(e_sel));
    check($sformatf("%s bus_addr", nm), ad_s, e_addr);
    check($sformatf("%s rd_data", nm), rd_s, e_rd);
  endtask

  initial begin
    logic        wr, uns, mis, err;
    logic [1:0]  sz;
    logic [31:0] a, wd, rdat, edat;
    logic [63:0] lv;
    logic [3:0]  esel;
    int          ack_at, e_cyc, off, m;

    n_cmp = 0; n_err = 0; exp_rd = 0;
    req_rd = 0; req_wr = 0; unsigned_ld = 0; bus_ack = 0; size = 0;
    addr = 0; wr_data = 0; bus_dat_i = 0;
    r_req_rd = 0; r_req_wr = 0; r_uns = 0; r_ack = 0; r_size = 0;
    r_addr = 0; r_wd = 0; r_dat_i = 0;

    //                wr    sz     uns   addr       wdata         rdata         ack cyc mis   err   sel   baddr      dat_o         rd_data
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0000_0055, 32'h80FF_1234, 1, 1, 1'b0, 1'b0, 4'h8, 32'h100, 32'h5555_5555, 32'hFFFF_FF80};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0000_0055, 32'h80FF_1234, 1, 1, 1'b0, 1'b0, 4'h8, 32'h100, 32'h5555_5555, 32'h0000_0080};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0000_0000, 1, 1, 1'b0, 1'b0, 4'hC, 32'h200, 32'hABCD_ABCD, 32'h0000_0080};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0000_0000, 32'h0000_0000, 1, 0, 1'b1, 1'b0, 4'h0, 32'h000, 32'h0000_0000, 32'h0000_0080};
    tbl[4]  = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0000_0000, 32'h0000_0000, 1, 0, 1'b1, 1'b0, 4'h0, 32'h000, 32'h0000_0000, 32'h0000_0080};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h200, 32'h1111_1111, 32'hCAFE_F00D, 0, 4, 1'b0, 1'b1, 4'hF, 32'h200, 32'h1111_1111, 32'h0000_0080};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h300, 32'h0000_0000, 32'h1234_5678, 4, 4, 1'b0, 1'b0, 4'hF, 32'h300, 32'h0000_0000, 32'h1234_5678};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h002, 32'h0000_0000, 32'h8001_7FFF, 2, 2, 1'b0, 1'b0, 4'hC, 32'h000, 32'h0000_0000, 32'hFFFF_8001};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h002, 32'h0000_0000, 32'h8001_7FFF, 2, 2, 1'b0, 1'b0, 4'hC, 32'h000, 32'h0000_0000, 32'h0000_8001};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h001, 32'h1234_56A5, 32'h0000_0000, 3, 3, 1'b0, 1'b0, 4'h2, 32'h000, 32'hA5A5_A5A5, 32'h0000_8001};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h00C, 32'hDEAD_BEEF, 32'h0000_0000, 1, 1, 1'b0, 1'b0, 4'hF, 32'h00C, 32'hDEAD_BEEF, 32'h0000_8001};
    tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h001, 32'h0000_0000, 32'h0000_0000, 1, 0, 1'b1, 1'b0, 4'h0, 32'h000, 32'h0000_0000, 32'h0000_8001};

    // Reset state
    reset = 1;
    #1 reset = 0;
    repeat (2) @(negedge clock);
    check("reset rd_data", 64'(rd_data), 0);
    check("reset bus_addr", 64'(bus_addr), 0);
    check("reset bus_dat_o", 64'(bus_dat_o), 0);
    check("reset bus_sel", 64'(bus_sel), 0);
    check("reset bus_cyc", 64'(bus_cyc), 0);
    check("reset bus_stb", 64'(bus_stb), 0);
    check("reset bus_we", 64'(bus_we), 0);
    check("reset busy", 64'(busy), 0);
    check("reset done", 64'(done), 0);
    check("reset misaligned", 64'(misaligned), 0);
    check("reset bus_error", 64'(bus_error), 0);
    check("reset rd_data64", r_rd, 0);
    reset = 1;
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
          tbl[i].rdata, tbl[i].ack_at, tbl[i].e_cyc, tbl[i].e_mis, tbl[i].e_err, tbl[i].e_sel,
          tbl[i].e_addr, tbl[i].e_dat, tbl[i].e_rd);
      exp_rd = tbl[i].e_rd;
    end

    // Ack while idle must be ignored
    bus_ack = 1; bus_dat_i = 32'h7777_7777;
    repeat (2) begin
      @(posedge clock); @(negedge clock);
      check("idle_ack busy", 64'(busy), 0);
      check("idle_ack done", 64'(done), 0);
      check("idle_ack rd_data", 64'(rd_data), 64'(exp_rd));
    end
    bus_ack = 0;

    // Async reset in the middle of a bus cycle
    req_rd = 1; req_wr = 0; size = 2'd2; unsigned_ld = 0; addr = 32'h400; wr_data = 0;
    @(posedge clock); @(negedge clock);
    req_rd = 0;
    check("midrst cyc_before", 64'(bus_cyc), 1);
    @(posedge clock); @(negedge clock);
    #2 reset = 0;
    #1;
    check("midrst cyc", 64'(bus_cyc), 0);
    check("midrst stb", 64'(bus_stb), 0);
    check("midrst busy", 64'(busy), 0);
    check("midrst rd_data", 64'(rd_data), 0);
    @(negedge clock);
    check("midrst done", 64'(done), 0);
    reset = 1;
    exp_rd = 0;
    @(posedge clock); @(negedge clock);
    check("midrst done_after", 64'(done), 0);
    txn("post_reset LW", 1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 32'h0BAD_F00D, 1, 1, 1'b0, 1'b0,
        4'hF, 32'h404, 32'h0, 32'h0BAD_F00D);
    exp_rd = 32'h0BAD_F00D;

    // 64-bit datapath
    txn64("rv64 LWU", 2'd2, 1'b1, 64'h1004, 64'hF000_0001_0000_0000, 8'hF0, 64'h1000,
          64'h0000_0000_F000_0001);
    txn64("rv64 LW", 2'd2, 1'b0, 64'h1004, 64'hF000_0001_0000_0000, 8'hF0, 64'h1000,
          64'hFFFF_FFFF_F000_0001);
    txn64("rv64 LD", 2'd3, 1'b1, 64'h1008, 64'h8000_0000_0000_0001, 8'hFF, 64'h1008,
          64'h8000_0000_0000_0001);

    // Random traffic against the reference model
    for (int k = 0; k < 300; k++) begin
      wr = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      a = $urandom; wd = $urandom; rdat = $urandom;
      ack_at = $urandom_range(0, 5);
      off = int'(a[1:0]);
      mis = ref_mis(int'(sz), a[2:0], 32);
      if (mis) e_cyc = 0;
      else if (ack_at >= 1 && ack_at <= TO) e_cyc = ack_at;
      else e_cyc = TO;
      err = !mis && (ack_at == 0 || ack_at > TO);
      if (!mis && !err && !wr) begin
        lv = ref_load({32'h0, rdat}, off, int'(sz), uns, 32);
        exp_rd = lv[31:0];
      end
      m = (1 << (1 << sz)) - 1;
      esel = 4'((m << off) & 15);
      case (sz)
        2'd0:    edat = {24'h0, wd[7:0]} * 32'h0101_0101;
        2'd1:    edat = {16'h0, wd[15:0]} * 32'h0001_0001;
        default: edat = wd;
      endcase
      txn($sformatf("rnd%0d", k), wr, sz, uns, a, wd, rdat, ack_at, e_cyc, mis, err,
          esel, a & 32'hFFFF_FFFC, edat, exp_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
